// File: rtl/noise_src.sv
// noise_src: burst stimulus source, baseline plus LFSR noise, then zero tail.
// Define NOISE_SRC_SAT_EN to clamp samples; otherwise sums wrap modulo 2^WIDTH.
module noise_src #(
    parameter int          WIDTH = 8,
    parameter logic [15:0] SEED  = 16'hACE1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             start,
    input  logic [WIDTH-1:0] base,
    input  logic [3:0]       amp_sh,
    input  logic [7:0]       n_samp,
    input  logic [7:0]       drop_len,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    output logic             busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DROP = 2'd2;

    logic [1:0]       state;
    logic [7:0]       cnt;
    logic [15:0]      lfsr;
    logic [15:0]      lfsr_nxt;
    logic [WIDTH-1:0] base_r;
    logic [3:0]       amp_r;
    logic [7:0]       drop_r;

    logic signed [WIDTH+1:0] noise_ext;
    logic signed [WIDTH+1:0] noise;
    logic signed [WIDTH+1:0] sum;
    logic [WIDTH-1:0]        sample;

    // Fibonacci step, taps 16/14/13/11
    always_comb begin
        lfsr_nxt = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end

    // Scaled signed noise added to the baseline, then clamped or wrapped
    always_comb begin
        noise_ext = {{(WIDTH-6){lfsr[7]}}, lfsr[7:0]};
        noise     = '0;
        if (!amp_r[3]) begin
            noise = noise_ext >>> amp_r[2:0];
        end
        sum = signed'({2'b00, base_r}) + noise;
`ifdef NOISE_SRC_SAT_EN
        if (sum[WIDTH+1]) begin
            sample = '0;
        end else if (sum[WIDTH]) begin
            sample = '1;
        end else begin
            sample = sum[WIDTH-1:0];
        end
`else
        sample = sum[WIDTH-1:0];
`endif
    end

    // Burst sequencer; busy tracks exactly the cycles that carry a sample
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            lfsr      <= SEED;
            base_r    <= '0;
            amp_r     <= '0;
            drop_r    <= '0;
            out       <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else if (!en) begin
            out_valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    if (start && !busy) begin
                        base_r <= base;
                        amp_r  <= amp_sh;
                        drop_r <= drop_len;
                        lfsr   <= SEED;
                        if (n_samp != 8'd0) begin
                            state <= S_RUN;
                            cnt   <= n_samp;
                        end else if (drop_len != 8'd0) begin
                            state <= S_DROP;
                            cnt   <= drop_len;
                        end
                    end
                end
                S_RUN: begin
                    out       <= sample;
                    out_valid <= 1'b1;
                    busy      <= 1'b1;
                    lfsr      <= lfsr_nxt;
                    if (cnt == 8'd1) begin
                        if (drop_r != 8'd0) begin
                            state <= S_DROP;
                            cnt   <= drop_r;
                        end else begin
                            state <= S_IDLE;
                            cnt   <= '0;
                        end
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                S_DROP: begin
                    out       <= '0;
                    out_valid <= 1'b1;
                    busy      <= 1'b1;
                    cnt       <= cnt - 8'd1;
                    if (cnt == 8'd1) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/noise_src.md
Name: noise_src

Overview:
- Stimulus source for the 8-bit moving-average filter: the producer end of its sample stream.
- Generates a burst of 8-bit samples equal to a programmable baseline plus pseudo-random noise of programmable amplitude, followed by a run of zero samples that exercises the filter's decay.
- One sample per enabled clock, with an explicit valid flag.
- Used in block-level benches and as an on-chip self-test source ahead of the filter input.

Parameters:
- WIDTH, 8, sample width in bits.
- SEED, 16'hACE1, LFSR load value on reset and on every accepted start.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  clock enable; low freezes all state.
- start  input  1  single-cycle request to begin a burst; honoured only in IDLE.
- base  input  WIDTH  baseline value, latched on accepted start.
- amp_sh  input  4  noise attenuation shift, latched on start; values >=8 force noise to 0.
- n_samp  input  8  number of noisy samples in the burst, latched on start.
- drop_len  input  8  number of zero samples after the burst, latched on start.
- out  output  WIDTH  current sample (registered).
- out_valid  output  1  out holds a new sample this cycle.
- busy  output  1  high in RUN or DROP.

Behaviour:
- Reset values: out=0, out_valid=0, busy=0, state=IDLE, LFSR=SEED, counter=0.
- FSM states: IDLE, RUN, DROP.
  - IDLE: out_valid=0; out holds its last value.
  - IDLE, start & en: latch base, amp_sh, n_samp, drop_len; load LFSR=SEED. Go to RUN if n_samp!=0; else DROP if drop_len!=0; else stay IDLE (no samples).
  - RUN: each en cycle emits one sample, out_valid=1. After n_samp samples go to DROP if drop_len!=0, else IDLE.
  - DROP: each en cycle emits out=0, out_valid=1. After drop_len samples go to IDLE.
- Latency: first sample is registered on the first en edge after the start edge, so out_valid rises one cycle after start is sampled.
- Burst timing: RUN and DROP together are exactly n_samp+drop_len valid cycles when en is held high. busy is high on exactly those cycles.
- Noise term:
  - noise = sign-extended LFSR[7:0] arithmetic-shifted right by amp_sh; noise=0 when amp_sh>=8.
  - The first RUN sample uses the SEED value.
  - The LFSR advances once after each RUN sample. It does not advance in DROP or IDLE.
- LFSR: 16-bit Fibonacci, polynomial x^16+x^14+x^13+x^11+1. Shift left; bit0 <= b15^b13^b12^b10.
- Arithmetic: sum = base + noise, computed at WIDTH+2 bits signed. With the default build, sum is clamped to 0..2^WIDTH-1.
- start while busy: ignored; the latched config is unchanged.
- en low in any state: out, FSM, counters and LFSR hold; out_valid=0; start is ignored.
- rst mid-burst: immediate return to reset values on that edge; rst has priority over start.

Optional Feature:
- Macro: NOISE_SRC_SAT_EN.
  - Defined (default build): sum saturates to the range 0..2^WIDTH-1.
  - Undefined: sum is truncated to WIDTH bits (modulo 2^WIDTH wrap). This is used to stress the filter with discontinuities.
  - All other behaviour is identical in both builds.

Test Plan:
- Clean burst: base=124, amp_sh=8, n_samp=10, drop_len=13, en=1, start pulse.
  - Required: out_valid rises 1 cycle later.
  - Then 10 samples of 124, followed by 13 samples of 0.
  - busy high for exactly 23 cycles, then IDLE with out_valid=0.
- First noisy sample: base=128, amp_sh=0.
  - Required: first out=97 (128 + 0xE1 = 128-31).
  - Second out = 128 + sext(next LFSR[7:0]), checked against a reference LFSR model.
- Saturation: base=10, amp_sh=0.
  - Required: first out=0 with NOISE_SRC_SAT_EN defined; out=235 without it.
- en gating: toggle en 1/0 every cycle during a burst with n_samp=4, drop_len=2.
  - Required: exactly 6 valid samples, identical values to the en=1 run.
  - out_valid=0 on every en=0 cycle; total duration 12 cycles.
- Boundaries:
  - n_samp=0, drop_len=3: exactly 3 zero samples.
  - n_samp=0, drop_len=0: no out_valid, busy stays 0.
  - start pulsed mid-burst: ignored, burst length unchanged.
- Reset mid-burst: assert rst on the 5th RUN sample.
  - Required: next cycle out=0, out_valid=0, busy=0.
  - A following start reproduces the identical sequence from SEED.
